// File: rtl/fifo_read_port_pkg.sv
// Shared types, limits and helpers for the FIFO read-port controller.
package fifo_pkg;

    // Deepest memory read latency the latency pipe is built for.
    localparam int unsigned MAXREADLATENCY = 2;

    // Counter width able to hold the values 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Occupancy sized for the widest legal case: in-flight reads plus buffered words.
    localparam int unsigned OCCW = $clog2(MAXREADLATENCY + (MAXREADLATENCY + 2) + 1);
    typedef logic [OCCW-1:0] occ_t;

endpackage

// File: rtl/fifo_read_port_if.sv
// FIFO-side read handshake plus consumer-side valid/ready stream.
interface fifo_read_port_if #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned CNTW      = 2
);
    logic                 fifoEmpty;
    logic                 fifoReadReq;
    logic [DATAWIDTH-1:0] fifoData;
    logic                 outValid;
    logic                 outReady;
    logic [DATAWIDTH-1:0] outData;
    logic [CNTW-1:0]      bufCount;

    // Controller side.
    modport master (
        input  fifoEmpty, fifoData, outReady,
        output fifoReadReq, outValid, outData, bufCount
    );

    // FIFO and consumer side.
    modport slave (
        output fifoEmpty, fifoData, outReady,
        input  fifoReadReq, outValid, outData, bufCount
    );
endinterface

// File: rtl/fifo_read_port_small_sync_fifo.sv
// Small circular buffer with any depth, simultaneous push/pop and a registered head word.
module small_sync_fifo #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned CNTW      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [DATAWIDTH-1:0] i_data,
    output logic [DATAWIDTH-1:0] o_head,
    output logic [CNTW-1:0]      o_count
);
    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATAWIDTH-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]      r_rd_ptr;
    logic [PTRW-1:0]      r_wr_ptr;
    logic [CNTW-1:0]      r_count;
    logic [DATAWIDTH-1:0] r_head;
    logic [DATAWIDTH-1:0] w_head_nxt;
    logic                 w_pop;
    logic                 w_push;

    // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNTW'(DEPTH)) || w_pop);

    // Next head word: the following entry on pop, the incoming word when it lands at the head.
    always_comb begin
        w_head_nxt = r_head;
        if (w_pop) begin
            if (r_count > CNTW'(1)) begin
                w_head_nxt = r_mem[ptr_inc(r_rd_ptr)];
            end else if (w_push) begin
                w_head_nxt = i_data;
            end
        end else if (w_push && (r_count == '0)) begin
            w_head_nxt = i_data;
        end
    end

    // Storage array; contents need no reset because the count gates their use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_head <= w_head_nxt;
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;
endmodule

// File: rtl/fifo_read_port.sv
// Read-side controller: credit-based FIFO read requests, read-latency pipe, output stream buffer.
module fifo_read_port
    import fifo_pkg::*;
#(
    parameter int unsigned DATAWIDTH   = 8,
    parameter int unsigned READLATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    fifo_read_port_if.master bus
);
    localparam int unsigned BUFDEPTH = READLATENCY + 2;
    localparam int unsigned CNTW     = cnt_width(BUFDEPTH);

    if (READLATENCY == 0 || READLATENCY > MAXREADLATENCY) begin : g_bad_latency
        $error("fifo_read_port: READLATENCY must be in 1..%0d", MAXREADLATENCY);
    end

    logic [READLATENCY-1:0] r_pipe;
    occ_t                   w_inflight;
    logic                   w_req;
    logic                   w_push;
    logic                   w_pop;
    logic [CNTW-1:0]        w_count;
    logic [DATAWIDTH-1:0]   w_head;

    // Count reads issued but not yet returned by the FIFO.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < int'(READLATENCY); i++) begin
            w_inflight = w_inflight + occ_t'(r_pipe[i]);
        end
    end

    // Only request when every outstanding word is guaranteed a buffer slot.
    assign w_req  = !reset && !bus.fifoEmpty
                    && ((w_inflight + occ_t'(w_count)) < occ_t'(BUFDEPTH));
    assign w_push = r_pipe[READLATENCY-1];
    assign w_pop  = bus.outValid && bus.outReady;

    // Latency pipe: a set bit leaving the top marks fifoData valid this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= (r_pipe << 1) | READLATENCY'(w_req);
        end
    end

    small_sync_fifo #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (BUFDEPTH),
        .CNTW      (CNTW)
    ) u_buf (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.fifoData),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.fifoReadReq = w_req;
    assign bus.outValid    = (w_count != '0);
    assign bus.outData     = w_head;
    assign bus.bufCount    = w_count;
endmodule

// File: tb/tb_fifo_read_port.sv
// Directed bench: two controllers (READLATENCY 1 and 2) fed by a behavioural FIFO model.
module tb_fifo_read_port;
    import fifo_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned LA  = 1;
    localparam int unsigned LB  = 2;
    localparam int unsigned DA  = LA + 2;
    localparam int unsigned DB  = LB + 2;
    localparam int unsigned CWA = cnt_width(DA);
    localparam int unsigned CWB = cnt_width(DB);

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    fifo_read_port_if #(.DATAWIDTH(DW), .CNTW(CWA)) ia ();
    fifo_read_port_if #(.DATAWIDTH(DW), .CNTW(CWB)) ib ();

    fifo_read_port #(.DATAWIDTH(DW), .READLATENCY(LA)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    fifo_read_port #(.DATAWIDTH(DW), .READLATENCY(LB)) dut_b (.clk(clk), .reset(reset), .bus(ib));

    always #5 clk = ~clk;

    // FIFO model state and scoreboards.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] expa[$];
    logic [7:0] expb[$];
    logic       req_sa = 1'b0, req_sb = 1'b0;
    logic       arrive_a = 1'b0, arrive_b = 1'b0;
    logic       vb0 = 1'b0;
    logic [7:0] shb0 = '0;
    logic       hold_a = 1'b0;
    int         issued_a = 0, issued_b = 0, xfer_a = 0, xfer_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_a(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) qa.push_back(base + 8'(i));
        ia.fifoEmpty = (qa.size() == 0) || hold_a;
    endtask

    task automatic load_b(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) qb.push_back(base + 8'(i));
        ib.fifoEmpty = (qb.size() == 0);
    endtask

    // FIFO and read pointer share the reset: discard everything on the model side.
    task automatic clear_a();
        qa.delete();
        expa.delete();
        req_sa       = 1'b0;
        arrive_a     = 1'b0;
        ia.fifoEmpty = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain_a(input string tag);
        int n = 0;
        ia.outReady = 1'b1;
        while ((qa.size() != 0 || expa.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(qa.size() + expa.size()), 32'd0);
    endtask

    // FIFO model, latency 1: pop on the edge after a request, data valid the next cycle.
    always @(posedge clk) begin
        #1;
        arrive_a = 1'b0;
        if (req_sa && qa.size() != 0) begin
            ia.fifoData = qa.pop_front();
            expa.push_back(ia.fifoData);
            arrive_a = 1'b1;
        end
        ia.fifoEmpty = (qa.size() == 0) || hold_a;
    end

    // FIFO model, latency 2: one extra stage before the data appears.
    always @(posedge clk) begin
        #1;
        arrive_b = vb0;
        if (vb0) ib.fifoData = shb0;
        vb0 = 1'b0;
        if (req_sb && qb.size() != 0) begin
            shb0 = qb.pop_front();
            expb.push_back(shb0);
            vb0 = 1'b1;
        end
        ib.fifoEmpty = (qb.size() == 0);
    end

    // Monitor A: request capture, overflow guard, in-order delivery.
    always @(negedge clk) begin
        if (reset) begin
            req_sa = 1'b0;
        end else begin
            req_sa = ia.fifoReadReq;
            if (req_sa) issued_a++;
            if (arrive_a) check("a_push_room", 32'(ia.bufCount < CWA'(DA)), 32'd1);
            if (ia.outValid && ia.outReady) begin
                check("a_sb_nonempty", 32'(expa.size() != 0), 32'd1);
                if (expa.size() != 0) check("a_order", 32'(ia.outData), 32'(expa.pop_front()));
                xfer_a++;
            end
        end
    end

    // Monitor B: same plus the outstanding-word bound.
    always @(negedge clk) begin
        if (reset) begin
            req_sb = 1'b0;
        end else begin
            req_sb = ib.fifoReadReq;
            if (req_sb) begin
                issued_b++;
                check("b_outstanding", 32'((issued_b - xfer_b) <= int'(DB)), 32'd1);
            end
            if (arrive_b) check("b_push_room", 32'(ib.bufCount < CWB'(DB)), 32'd1);
            if (ib.outValid && ib.outReady) begin
                check("b_sb_nonempty", 32'(expb.size() != 0), 32'd1);
                if (expb.size() != 0) check("b_order", 32'(ib.outData), 32'(expb.pop_front()));
                xfer_b++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        reset        = 1'b1;
        ia.fifoEmpty = 1'b1;
        ia.fifoData  = '0;
        ia.outReady  = 1'b0;
        ib.fifoEmpty = 1'b1;
        ib.fifoData  = '0;
        ib.outReady  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // Test 1: fill two words, then reset mid-clock.
        load_a(8'h01, 2);
        repeat (5) @(negedge clk);
        check("t1_pre_count", 32'(ia.bufCount), 32'd2);
        check("t1_pre_data", 32'(ia.outData), 32'h01);
        #2;
        reset = 1'b1;
        clear_a();
        #1;
        check("t1_rst_valid", 32'(ia.outValid), 32'd0);
        check("t1_rst_data", 32'(ia.outData), 32'd0);
        check("t1_rst_count", 32'(ia.bufCount), 32'd0);
        check("t1_rst_req", 32'(ia.fifoReadReq), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t1_post_valid", 32'(ia.outValid), 32'd0);
            check("t1_post_req", 32'(ia.fifoReadReq), 32'd0);
            check("t1_post_count", 32'(ia.bufCount), 32'd0);
        end

        // Test 2: five-word stream at full rate, latency 1.
        step();
        ia.outReady = 1'b1;
        load_a(8'h11, 5);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("t2_req", 32'(ia.fifoReadReq), 32'(i <= 4));
            check("t2_valid", 32'(ia.outValid), 32'(i >= 2 && i <= 6));
            if (i >= 2 && i <= 6) check("t2_data", 32'(ia.outData), 32'(8'h11 + 8'(i - 2)));
        end
        drain_a("t2_drain");

        // Test 3: backpressure stops requests once credits are used up.
        step();
        ia.outReady = 1'b0;
        s = issued_a;
        load_a(8'h11, 6);
        repeat (8) @(negedge clk);
        check("t3_issued", 32'(issued_a - s), 32'd3);
        check("t3_count", 32'(ia.bufCount), 32'd3);
        check("t3_valid", 32'(ia.outValid), 32'd1);
        check("t3_data", 32'(ia.outData), 32'h11);
        repeat (2) @(negedge clk);
        check("t3_data_hold", 32'(ia.outData), 32'h11);
        check("t3_req_stop", 32'(ia.fifoReadReq), 32'd0);
        s = xfer_a;
        step();
        drain_a("t3_drain");
        check("t3_xfers", 32'(xfer_a - s), 32'd6);

        // Test 4: fifoEmpty toggling every 2 cycles with random consumer stalls.
        step();
        s = xfer_a;
        load_a(8'h30, 16);
        for (int i = 0; i < 60; i++) begin
            step();
            if (i % 2 == 0) hold_a = !hold_a;
            ia.fifoEmpty = (qa.size() == 0) || hold_a;
            ia.outReady  = 1'($urandom_range(0, 1));
        end
        hold_a = 1'b0;
        ia.fifoEmpty = (qa.size() == 0);
        drain_a("t4_drain");
        check("t4_xfers", 32'(xfer_a - s), 32'd16);

        // Test 5: reset with two words buffered and one read in flight.
        step();
        ia.outReady = 1'b0;
        load_a(8'h41, 6);
        repeat (4) @(negedge clk);
        check("t5_pre_count", 32'(ia.bufCount), 32'd2);
        #1;
        reset = 1'b1;
        clear_a();
        #1;
        check("t5_rst_valid", 32'(ia.outValid), 32'd0);
        @(negedge clk);
        check("t5_next_valid", 32'(ia.outValid), 32'd0);
        check("t5_next_count", 32'(ia.bufCount), 32'd0);
        step();
        reset = 1'b0;
        s = xfer_a;
        load_a(8'h51, 3);
        ia.outReady = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_first_data", 32'(ia.outData), 32'h51);
        drain_a("t5_drain");
        check("t5_xfers", 32'(xfer_a - s), 32'd3);

        // Test 6: latency 2, five-word stream at full rate.
        step();
        ib.outReady = 1'b1;
        s = xfer_b;
        load_b(8'h61, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_req", 32'(ib.fifoReadReq), 32'(i <= 4));
            check("t6_valid", 32'(ib.outValid), 32'(i >= 3 && i <= 7));
            if (i >= 3 && i <= 7) check("t6_data", 32'(ib.outData), 32'(8'h61 + 8'(i - 3)));
        end
        check("t6_xfers", 32'(xfer_b - s), 32'd5);
        check("t6_sb_empty", 32'(expb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
